// File: rtl/dec_top_if.sv
// Read-path bundle for the SEC-DED decoder: codeword in, corrected data out.
// master = upstream/downstream side, slave = decoder; counters ride along.
interface dec_top_if #(
  parameter int CNT_W = 16
);
  logic [38:0]      IN;
  logic             IN_VALID;
  logic             IN_READY;
  logic [31:0]      OUT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             SBE;
  logic             DBE;
  logic [6:0]       SYND;
  logic             CNT_CLR;
  logic [CNT_W-1:0] SBE_CNT;
  logic [CNT_W-1:0] DBE_CNT;

  modport master (
    output IN, IN_VALID, OUT_READY, CNT_CLR,
    input  IN_READY, OUT, OUT_VALID, SBE, DBE,
    input  SYND, SBE_CNT, DBE_CNT
  );

  modport slave (
    input  IN, IN_VALID, OUT_READY, CNT_CLR,
    output IN_READY, OUT, OUT_VALID, SBE, DBE,
    output SYND, SBE_CNT, DBE_CNT
  );
endinterface

// File: rtl/dec_top.sv
// Hsiao (39,32) SEC-DED decoder, 2-stage valid/ready pipe: S1 syndrome,
// S2 correct/classify. Ports: clk, rst (async high), bus (dec_top_if.slave).
// Optional error counters enabled by macro SECDED_ERR_CNT_EN.
module dec_top #(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  dec_top_if.slave bus
);

  // Row masks of the parity-check matrix, M[k] = data bits in check k.
  localparam logic [6:0][31:0] M = {
    32'h5403FF10, 32'h8B503E88, 32'hA2BBC244,
    32'h7D9C4422, 32'hC06C89E1, 32'h13E5101F,
    32'h2C0221FF
  };

  typedef struct packed {
    logic [31:0] d;
    logic [6:0]  s;
  } s1_t;

  typedef struct packed {
    logic [31:0] d;
    logic [6:0]  s;
    logic        sbe;
    logic        dbe;
  } s2_t;

  function automatic logic [6:0] col(input int j);
    logic [6:0] c;
    for (int k = 0; k < 7; k++) c[k] = M[k][j];
    return c;
  endfunction

  logic v1, v2;
  logic adv1, adv2;
  s1_t  s1;
  s2_t  s2;
  logic [6:0]  syn;
  logic [31:0] flip;
  s2_t  nx2;
  logic onehot;

  assign adv2 = !v2 | bus.OUT_READY;
  assign adv1 = !v1 | adv2;
  assign bus.IN_READY = adv1;

  always_comb begin
    syn = '0;
    for (int k = 0; k < 7; k++)
      syn[k] = bus.IN[32+k] ^ (^(bus.IN[31:0] & M[k]));
  end

  always_comb begin
    flip = '0;
    for (int j = 0; j < 32; j++)
      flip[j] = (s1.s == col(j));
    onehot = (s1.s != '0) &&
             ((s1.s & (s1.s - 7'd1)) == '0);
    nx2.d   = s1.d ^ flip;
    nx2.s   = s1.s;
    nx2.sbe = (|flip) | onehot;
    nx2.dbe = (s1.s != '0) & !((|flip) | onehot);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv1) begin
      v1 <= bus.IN_VALID;
      if (bus.IN_VALID)
        s1 <= '{d: bus.IN[31:0], s: syn};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      s2 <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1)
        s2 <= nx2;
    end
  end

  assign bus.OUT_VALID = v2;
  assign bus.OUT       = s2.d;
  assign bus.SYND      = s2.s;
  assign bus.SBE       = s2.sbe;
  assign bus.DBE       = s2.dbe;

`ifdef SECDED_ERR_CNT_EN
  logic [CNT_W-1:0] sc, dc;
  logic fire;

  assign fire = v2 & bus.OUT_READY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc <= '0;
      dc <= '0;
    end else if (bus.CNT_CLR) begin
      sc <= '0;
      dc <= '0;
    end else begin
      if (fire & s2.sbe & ~&sc)
        sc <= sc + 1'b1;
      if (fire & s2.dbe & ~&dc)
        dc <= dc + 1'b1;
    end
  end

  assign bus.SBE_CNT = sc;
  assign bus.DBE_CNT = dc;
`else
  logic unused_clr;
  assign unused_clr  = bus.CNT_CLR;
  assign bus.SBE_CNT = '0;
  assign bus.DBE_CNT = '0;
`endif

endmodule

// File: tb/tb_dec_top.sv
// Bench for dec_top: randomized codewords vs. a set-list reference model,
// per-cycle compare of outputs, ordering, stalls, reset and counters.
`timescale 1ns/1ps
module tb_dec_top;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec_top_if #(.CNT_W(CNT_W)) bus ();
  dec_top #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [6:0]  s;
    logic        sbe;
    logic        dbe;
  } exp_t;

  int checks = 0;
  int fails  = 0;
  exp_t q[$];
  int mc_s = 0;
  int mc_d = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Check-set membership written straight from the code's row lists.
  function automatic bit member(input int k, input int j);
    case (k)
      0: return j inside {[0:8], 13, 17, 26, 27, 29};
      1: return j inside {[0:4], 12, 16, 18, [21:25], 28};
      2: return j inside {0, [5:8], 11, 15, 18, 19, 21, 22, 30, 31};
      3: return j inside {1, 5, 10, 14, [18:20], 23, 24, [26:30]};
      4: return j inside {2, 6, 9, [14:17], [19:21], 23, 25, 29, 31};
      5: return j inside {3, 7, [9:13], 20, 22, 24, 25, 27, 31};
      6: return j inside {4, [8:17], 26, 28, 30};
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] encode(input logic [31:0] d);
    logic [6:0] c;
    c = '0;
    for (int k = 0; k < 7; k++)
      for (int j = 0; j < 32; j++)
        if (member(k, j)) c[k] = c[k] ^ d[j];
    return c;
  endfunction

  function automatic logic [6:0] model_synd(input logic [38:0] w);
    return w[38:32] ^ encode(w[31:0]);
  endfunction

  function automatic exp_t classify(input logic [38:0] w);
    exp_t e;
    logic [6:0] s;
    logic [6:0] cj;
    bit hit;
    s = model_synd(w);
    e.d = w[31:0];
    e.s = s;
    e.sbe = 1'b0;
    e.dbe = 1'b0;
    hit = 1'b0;
    if (s != 0) begin
      for (int j = 0; j < 32; j++) begin
        cj = '0;
        for (int k = 0; k < 7; k++) cj[k] = member(k, j);
        if (cj == s) begin
          e.d[j] = ~e.d[j];
          hit = 1'b1;
        end
      end
      if (hit || $countones(s) == 1) e.sbe = 1'b1;
      else e.dbe = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [38:0] rnd_word();
    logic [31:0] d;
    logic [38:0] w;
    int m, a, b;
    d = $urandom;
    w = {encode(d), d};
    m = $urandom_range(0, 9);
    a = $urandom_range(0, 38);
    b = (a + 1 + $urandom_range(0, 37)) % 39;
    if (m >= 3 && m < 9) w[a] = ~w[a];
    if (m >= 6 && m < 9) w[b] = ~w[b];
    if (m == 8) w[(b + 1 + a) % 39] = ~w[(b + 1 + a) % 39];
    if (m == 9) w = {7'($urandom), 32'($urandom)};
    return w;
  endfunction

  // Monitor: samples 1ns after each falling edge, i.e. with this
  // cycle's inputs settled and before the next rising edge.
  initial begin : mon
    exp_t e;
    logic [40:0] cur, prev;
    bit hold, fire;
    int idle;
    hold = 0;
    idle = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      cur = {bus.OUT, bus.SYND, bus.SBE, bus.DBE};
      if (rst) begin
        q.delete();
        mc_s = 0;
        mc_d = 0;
        hold = 0;
        idle = 0;
        chk("rst_out_valid", bus.OUT_VALID, 0);
        chk("rst_outputs", cur, 0);
        chk("rst_in_ready", bus.IN_READY, 1);
        chk("rst_counters", {bus.SBE_CNT, bus.DBE_CNT}, 0);
      end else begin
        chk("in_ready", bus.IN_READY,
            !(q.size() == 2 && !bus.OUT_READY));
        if (bus.OUT_VALID) begin
          idle = 0;
          if (q.size() == 0) chk("spurious_out", 1, 0);
          else begin
            e = q[0];
            chk("out_word", cur, {e.d, e.s, e.sbe, e.dbe});
          end
          if (hold) chk("stall_stable", cur, prev);
        end else begin
          if (hold) chk("stall_dropped", bus.OUT_VALID, 1);
          if (q.size() > 0) idle++;
          if (idle > 1) chk("latency", idle, 1);
        end
`ifdef SECDED_ERR_CNT_EN
        chk("sbe_cnt", bus.SBE_CNT, mc_s);
        chk("dbe_cnt", bus.DBE_CNT, mc_d);
`else
        chk("cnt_tied", {bus.SBE_CNT, bus.DBE_CNT}, 0);
`endif
        hold = bus.OUT_VALID && !bus.OUT_READY;
        prev = cur;
        fire = bus.OUT_VALID && bus.OUT_READY && q.size() > 0;
        if (fire) e = q.pop_front();
        if (bus.CNT_CLR) begin
          mc_s = 0;
          mc_d = 0;
        end else if (fire) begin
          if (e.sbe && mc_s < MAXC) mc_s++;
          if (e.dbe && mc_d < MAXC) mc_d++;
        end
        if (bus.IN_VALID && bus.IN_READY)
          q.push_back(classify(bus.IN));
      end
    end
  end

  task automatic drv(input logic v, input logic [38:0] w,
                     input logic r, input logic clr);
    @(negedge clk);
    bus.IN_VALID  = v;
    bus.IN        = w;
    bus.OUT_READY = r;
    bus.CNT_CLR   = clr;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drv(0, '0, 1, 0);
  endtask

  task automatic directed(input string nm, input logic [38:0] w,
                          input logic [31:0] eo, input logic [6:0] es,
                          input logic esbe, input logic edbe);
    int n;
    drv(1, w, 1, 0);
    drv(0, '0, 1, 0);
    n = 0;
    while (!bus.OUT_VALID && n < 4) begin
      drv(0, '0, 1, 0);
      n++;
    end
    chk({nm, "_valid"}, bus.OUT_VALID, 1);
    chk(nm, {bus.OUT, bus.SYND, bus.SBE, bus.DBE},
        {eo, es, esbe, edbe});
    drain(2);
  endtask

  initial begin : stim
    logic [38:0] w;
    int sent, n;
    bus.IN_VALID  = 0;
    bus.IN        = '0;
    bus.OUT_READY = 1;
    bus.CNT_CLR   = 0;

    chk("pin_encode_ffff", encode(32'hFFFFFFFF), 7'h24);
    chk("pin_synd_bit0", model_synd(39'h24FFFFFFFE), 7'h07);
    chk("pin_synd_bits01", model_synd(39'h0000000003), 7'h0C);

    repeat (3) @(negedge clk);
    #2 rst = 0;

    directed("zero", 39'h0, 32'h0, 7'h00, 0, 0);
    directed("ones_clean", 39'h24FFFFFFFF, 32'hFFFFFFFF, 7'h00, 0, 0);
    directed("ones_flip0", 39'h24FFFFFFFE, 32'hFFFFFFFF, 7'h07, 1, 0);
    directed("c2_flip", 39'h0400000000, 32'h0, 7'h04, 1, 0);
    directed("dbe_01", 39'h0000000003, 32'h00000003, 7'h0C, 0, 1);

    // 8 words with OUT_READY 1,0,0,...
    sent = 0;
    n = 0;
    while (sent < 8 && n < 100) begin
      drv(1, rnd_word(), (n % 3) == 0, 0);
      #1;
      if (bus.IN_READY) sent++;
      n++;
    end
    chk("stream8_sent", sent, 8);
    drain(6);
    chk("stream8_drained", q.size(), 0);

    // Reset with both stages full.
    for (int i = 0; i < 3; i++) drv(1, rnd_word(), 0, 0);
    drv(0, '0, 0, 0);
    chk("full_valid", bus.OUT_VALID, 1);
    chk("full_in_ready", bus.IN_READY, 0);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", bus.OUT_VALID, 0);
    chk("async_rst_out", bus.OUT, 0);
    chk("async_rst_ready", bus.IN_READY, 1);
    @(negedge clk);
    #2 rst = 0;
    drain(4);

    // Counters: 20 SBE words back to back.
    drv(0, '0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      w = {encode(32'(i * 77)), 32'(i * 77)};
      w[5] = ~w[5];
      drv(1, w, 1, 0);
    end
    drain(4);
`ifdef SECDED_ERR_CNT_EN
    chk("sbe_cnt_sat", bus.SBE_CNT, 15);
`else
    chk("sbe_cnt_off", bus.SBE_CNT, 0);
`endif
    // Clear coinciding with an SBE transfer.
    w = {encode(32'h1234), 32'h1234};
    w[9] = ~w[9];
    drv(1, w, 0, 0);
    drv(0, '0, 0, 0);
    n = 0;
    while (!bus.OUT_VALID && n < 4) begin
      drv(0, '0, 0, 0);
      n++;
    end
    chk("clr_word_valid", bus.OUT_VALID, 1);
    drv(0, '0, 1, 1);
    drv(0, '0, 1, 0);
    chk("clr_priority", bus.SBE_CNT, 0);
    drain(2);

    // Randomized traffic with random backpressure and clears.
    for (int i = 0; i < 3000; i++)
      drv($urandom_range(0, 3) != 0, rnd_word(),
          $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    drain(6);
    chk("final_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
